// File: rtl/fwd_net.sv
// rtl/fwd_net.sv - operand forwarding network with load-use detection
// Youngest matching producer wins per read port; operands are registered at the ID->EX boundary.
module fwd_net #(
  parameter int NPORT = 2,
  parameter int NSRC  = 3,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [NPORT-1:0]      rd_valid,
  input  logic [NPORT*AW-1:0]   rd_addr,
  input  logic [NSRC-1:0]       src_we,
  input  logic [NSRC*AW-1:0]    src_waddr,
  input  logic [NSRC*DW-1:0]    src_wdata,
  input  logic [NSRC-1:0]       src_pend,
  output logic [NPORT-1:0]      fwd_sel,
  output logic [NPORT*DW-1:0]   fwd_data,
  output logic                  stallreq,
  output logic [31:0]           fwd_cnt,
  output logic [31:0]           luse_cnt
);

  logic [NPORT-1:0]    fwd_sel_q, sel_d;
  logic [NPORT*DW-1:0] fwd_data_q, data_d;
  logic [31:0]         fwd_cnt_q, luse_cnt_q;
  logic [NPORT-1:0]    luse_p;
  logic [31:0]         nsel;
  logic [32:0]         fwd_sum;
  logic                m_any, m_pend;
  logic [DW-1:0]       m_data;
  logic [AW-1:0]       addr;

  always_comb begin
    sel_d  = '0;
    data_d = '0;
    luse_p = '0;
    nsel   = '0;
    m_any  = 1'b0;
    m_pend = 1'b0;
    m_data = '0;
    addr   = '0;
    for (int p = 0; p < NPORT; p++) begin
      addr   = rd_addr[p*AW +: AW];
      m_any  = 1'b0;
      m_pend = 1'b0;
      m_data = '0;
      // Scan oldest to youngest so the youngest match overwrites the older ones.
      for (int i = NSRC - 1; i >= 0; i--) begin
        if (rd_valid[p] && (addr != '0) && src_we[i] && (src_waddr[i*AW +: AW] == addr)) begin
          m_any  = 1'b1;
          m_pend = src_pend[i];
          m_data = src_wdata[i*DW +: DW];
        end
      end
      if (m_any && !m_pend) begin
        sel_d[p]            = 1'b1;
        data_d[p*DW +: DW]  = m_data;
      end
      luse_p[p] = m_any && m_pend;
      nsel      = nsel + 32'(sel_d[p]);
    end
  end

  assign stallreq = ~rst & (|luse_p);
  assign fwd_sum  = {1'b0, fwd_cnt_q} + {1'b0, nsel};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_sel_q  <= '0;
      fwd_data_q <= '0;
      fwd_cnt_q  <= '0;
      luse_cnt_q <= '0;
    end else begin
      if (flush) begin
        fwd_sel_q  <= '0;
        fwd_data_q <= '0;
      end else if (!stall) begin
        fwd_sel_q  <= sel_d;
        fwd_data_q <= data_d;
        fwd_cnt_q  <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
      end
      // Load-use cycles are counted even while stalled; a flush kills the request.
      if (stallreq && !flush && (luse_cnt_q != 32'hFFFF_FFFF)) begin
        luse_cnt_q <= luse_cnt_q + 32'd1;
      end
    end
  end

  assign fwd_sel  = fwd_sel_q;
  assign fwd_data = fwd_data_q;
  assign fwd_cnt  = fwd_cnt_q;
  assign luse_cnt = luse_cnt_q;

endmodule

// File: tb/tb_fwd_net.sv
// tb/tb_fwd_net.sv - directed vector table plus random sweep for fwd_net
// Default instance is driven from a vector table and hand sequences; a 3-port/5-source instance runs against a model.
module tb_fwd_net;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [1:0]  rd_valid;
  logic [9:0]  rd_addr;
  logic [2:0]  src_we, src_pend;
  logic [14:0] src_waddr;
  logic [95:0] src_wdata;
  logic [1:0]  fwd_sel;
  logic [63:0] fwd_data;
  logic        stallreq;
  logic [31:0] fwd_cnt, luse_cnt;

  logic        s_rst, s_stall, s_flush;
  logic [2:0]  s_rd_valid;
  logic [8:0]  s_rd_addr;
  logic [4:0]  s_src_we, s_src_pend;
  logic [14:0] s_src_waddr;
  logic [39:0] s_src_wdata;
  logic [2:0]  s_fwd_sel;
  logic [23:0] s_fwd_data;
  logic        s_stallreq;
  logic [31:0] s_fwd_cnt, s_luse_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_net dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .rd_valid(rd_valid), .rd_addr(rd_addr),
    .src_we(src_we), .src_waddr(src_waddr), .src_wdata(src_wdata), .src_pend(src_pend),
    .fwd_sel(fwd_sel), .fwd_data(fwd_data), .stallreq(stallreq),
    .fwd_cnt(fwd_cnt), .luse_cnt(luse_cnt)
  );

  fwd_net #(.NPORT(3), .NSRC(5), .AW(3), .DW(8)) u_p3 (
    .clk(clk), .rst(s_rst), .stall(s_stall), .flush(s_flush),
    .rd_valid(s_rd_valid), .rd_addr(s_rd_addr),
    .src_we(s_src_we), .src_waddr(s_src_waddr), .src_wdata(s_src_wdata), .src_pend(s_src_pend),
    .fwd_sel(s_fwd_sel), .fwd_data(s_fwd_data), .stallreq(s_stallreq),
    .fwd_cnt(s_fwd_cnt), .luse_cnt(s_luse_cnt)
  );

  typedef struct {
    logic        st, fl;
    logic [1:0]  rv;
    logic [4:0]  a0, a1;
    logic [2:0]  we;
    logic [4:0]  w0, w1, w2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  pe;
    logic        e_sr;
    logic [1:0]  e_sel;
    logic [31:0] e0, e1, e_fc, e_lc;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic fl, input logic [1:0] rv,
                              input logic [4:0] a0, input logic [4:0] a1, input logic [2:0] we,
                              input logic [4:0] w0, input logic [4:0] w1, input logic [4:0] w2,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [2:0] pe);
    vec_t v;
    v.st = st; v.fl = fl; v.rv = rv; v.a0 = a0; v.a1 = a1; v.we = we;
    v.w0 = w0; v.w1 = w1; v.w2 = w2; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.pe = pe;
    v.e_sr = 1'b0; v.e_sel = '0; v.e0 = '0; v.e1 = '0; v.e_fc = '0; v.e_lc = '0;
    return v;
  endfunction

  task automatic av(input vec_t v, input logic sr, input logic [1:0] sel,
                    input logic [31:0] e0, input logic [31:0] e1,
                    input logic [31:0] fc, input logic [31:0] lc);
    v.e_sr = sr; v.e_sel = sel; v.e0 = e0; v.e1 = e1; v.e_fc = fc; v.e_lc = lc;
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    stall     = v.st;
    flush     = v.fl;
    rd_valid  = v.rv;
    rd_addr   = {v.a1, v.a0};
    src_we    = v.we;
    src_waddr = {v.w2, v.w1, v.w0};
    src_wdata = {v.d2, v.d1, v.d0};
    src_pend  = v.pe;
  endtask

  task automatic chk_regs(input string nm, input logic [1:0] sel, input logic [31:0] e0,
                          input logic [31:0] e1, input logic [31:0] fc, input logic [31:0] lc);
    chk({nm, " fwd_sel"}, 64'(fwd_sel), 64'(sel));
    chk({nm, " fwd_data"}, fwd_data, {e1, e0});
    chk({nm, " fwd_cnt"}, 64'(fwd_cnt), 64'(fc));
    chk({nm, " luse_cnt"}, 64'(luse_cnt), 64'(lc));
  endtask

  // Reference model for the swept instance.
  logic [2:0]  m_sel, n_sel;
  logic [23:0] m_data, n_data;
  logic [31:0] m_fc, m_lc;
  logic        m_sr;

  task automatic model_comb();
    logic hit;
    n_sel = '0; n_data = '0; m_sr = 1'b0;
    for (int p = 0; p < 3; p++) begin
      hit = 1'b0;
      for (int i = 0; i < 5; i++) begin
        if (!hit && s_rd_valid[p] && s_rd_addr[p*3 +: 3] != 3'd0 && s_src_we[i] &&
            s_src_waddr[i*3 +: 3] == s_rd_addr[p*3 +: 3]) begin
          hit = 1'b1;
          if (s_src_pend[i]) m_sr = 1'b1;
          else begin
            n_sel[p] = 1'b1;
            n_data[p*8 +: 8] = s_src_wdata[i*8 +: 8];
          end
        end
      end
    end
  endtask

  task automatic model_edge();
    int n;
    longint unsigned s;
    n = 0;
    for (int p = 0; p < 3; p++) n += int'(n_sel[p]);
    if (m_sr && !s_flush && m_lc != 32'hFFFF_FFFF) m_lc = m_lc + 1;
    if (s_flush) begin
      m_sel = '0; m_data = '0;
    end else if (!s_stall) begin
      m_sel = n_sel; m_data = n_data;
      s = longint'(m_fc) + longint'(n);
      m_fc = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    end
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; s_rst = 1'b1;
    drive(mk(0, 0, 2'b00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000));
    s_stall = 0; s_flush = 0; s_rd_valid = '0; s_rd_addr = '0;
    s_src_we = '0; s_src_waddr = '0; s_src_wdata = '0; s_src_pend = '0;
    #1;
    chk_regs("reset", 2'b00, 0, 0, 0, 0);
    chk("reset stallreq", 64'(stallreq), 0);

    av(mk(0, 0, 2'b01, 8, 0, 3'b101, 8, 0, 8, 32'h11, 0, 32'h33, 3'b000), 0, 2'b01, 32'h11, 0, 1, 0);
    av(mk(0, 0, 2'b10, 0, 4, 3'b011, 4, 4, 0, 0, 32'h55, 0, 3'b001), 1, 2'b00, 0, 0, 1, 1);
    av(mk(0, 0, 2'b01, 0, 0, 3'b001, 0, 0, 0, 32'hFFFF, 0, 0, 3'b000), 0, 2'b00, 0, 0, 1, 1);
    av(mk(0, 0, 2'b11, 7, 7, 3'b110, 0, 7, 7, 0, 32'h77, 32'h99, 3'b000), 0, 2'b11, 32'h77, 32'h77, 3, 1);
    av(mk(0, 0, 2'b01, 9, 0, 3'b011, 9, 9, 0, 32'hA0, 32'hB0, 0, 3'b010), 0, 2'b01, 32'hA0, 0, 4, 1);
    av(mk(0, 0, 2'b11, 3, 9, 3'b100, 0, 0, 9, 0, 0, 1, 3'b100), 1, 2'b00, 0, 0, 4, 2);
    av(mk(0, 0, 2'b00, 5, 0, 3'b001, 5, 0, 0, 5, 0, 0, 3'b000), 0, 2'b00, 0, 0, 4, 2);
    av(mk(0, 0, 2'b01, 5, 0, 3'b000, 5, 0, 0, 5, 0, 0, 3'b000), 0, 2'b00, 0, 0, 4, 2);
    av(mk(1, 0, 2'b10, 0, 4, 3'b001, 4, 0, 0, 0, 0, 0, 3'b001), 1, 2'b00, 0, 0, 4, 3);
    av(mk(0, 0, 2'b11, 1, 2, 3'b110, 0, 1, 2, 0, 32'h101, 32'h202, 3'b000), 0, 2'b11, 32'h101, 32'h202, 6, 3);
    av(mk(0, 1, 2'b11, 1, 2, 3'b110, 0, 1, 2, 0, 32'h101, 32'h202, 3'b000), 0, 2'b00, 0, 0, 6, 3);
    av(mk(0, 1, 2'b10, 0, 4, 3'b001, 4, 0, 0, 0, 0, 0, 3'b001), 1, 2'b00, 0, 0, 6, 3);

    @(negedge clk);
    rst = 1'b0; s_rst = 1'b0;
    foreach (vq[k]) begin
      @(negedge clk);
      drive(vq[k]);
      #1;
      chk($sformatf("v%0d stallreq", k), 64'(stallreq), 64'(vq[k].e_sr));
      @(posedge clk); #1;
      chk_regs($sformatf("v%0d", k), vq[k].e_sel, vq[k].e0, vq[k].e1, vq[k].e_fc, vq[k].e_lc);
    end

    // Capture, hold through three stalls with new sources, then flush+stall.
    @(negedge clk);
    drive(mk(0, 0, 2'b01, 6, 0, 3'b001, 6, 0, 0, 32'hAB, 0, 0, 3'b000));
    @(posedge clk); #1;
    chk_regs("cap_ab", 2'b01, 32'hAB, 0, 7, 3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(mk(1, 0, 2'b11, 6, 6, 3'b011, 6, 6, 0, 32'hCD + c, 32'hEE, 0, 3'b000));
      @(posedge clk); #1;
      chk_regs($sformatf("stall%0d", c), 2'b01, 32'hAB, 0, 7, 3);
    end
    @(negedge clk);
    drive(mk(1, 1, 2'b01, 6, 0, 3'b001, 6, 0, 0, 32'hCD, 0, 0, 3'b000));
    @(posedge clk); #1;
    chk_regs("flush_stall", 2'b00, 0, 0, 7, 3);

    // Reset during a stall discards held operand; first capture uses live data.
    @(negedge clk);
    drive(mk(0, 0, 2'b01, 6, 0, 3'b001, 6, 0, 0, 32'hAB, 0, 0, 3'b000));
    @(posedge clk); #1;
    chk_regs("cap_ab2", 2'b01, 32'hAB, 0, 8, 3);
    @(negedge clk);
    stall = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_regs("rst_mid_stall", 2'b00, 0, 0, 0, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    drive(mk(0, 0, 2'b01, 6, 0, 3'b001, 6, 0, 0, 32'h5A, 0, 0, 3'b000));
    @(posedge clk); #1;
    chk_regs("post_rst_cap", 2'b01, 32'h5A, 0, 1, 0);

    // Saturation of both counters.
    @(negedge clk);
    dut.fwd_cnt_q  = 32'hFFFF_FFFE;
    dut.luse_cnt_q = 32'hFFFF_FFFF;
    drive(mk(0, 0, 2'b11, 1, 2, 3'b011, 1, 2, 0, 32'h1, 32'h2, 0, 3'b000));
    @(posedge clk); #1;
    chk_regs("sat_fwd", 2'b11, 32'h1, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    drive(mk(0, 0, 2'b10, 0, 4, 3'b001, 4, 0, 0, 0, 0, 0, 3'b001));
    #1;
    chk("sat_luse stallreq", 64'(stallreq), 1);
    @(posedge clk); #1;
    chk_regs("sat_luse", 2'b00, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Async reset between edges while a load-use is pending.
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk_regs("async_rst", 2'b00, 0, 0, 0, 0);
    chk("async_rst stallreq", 64'(stallreq), 0);
    @(negedge clk);
    rst = 1'b0;

    // Random sweep of the 3-port / 5-source instance against the model.
    m_sel = '0; m_data = '0; m_fc = '0; m_lc = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      s_stall     = ($urandom_range(0, 7) == 0);
      s_flush     = ($urandom_range(0, 15) == 0);
      s_rd_valid  = 3'($urandom);
      for (int p = 0; p < 3; p++) s_rd_addr[p*3 +: 3] = 3'($urandom_range(0, 7));
      s_src_we    = 5'($urandom);
      for (int i = 0; i < 5; i++) begin
        s_src_waddr[i*3 +: 3] = 3'($urandom_range(0, 7));
        s_src_wdata[i*8 +: 8] = 8'($urandom);
        s_src_pend[i]         = ($urandom_range(0, 3) == 0);
      end
      model_comb();
      #1;
      chk($sformatf("sweep%0d stallreq", c), 64'(s_stallreq), 64'(m_sr));
      @(posedge clk); #1;
      model_edge();
      chk($sformatf("sweep%0d operands", c), {37'd0, s_fwd_sel, s_fwd_data}, {37'd0, m_sel, m_data});
      chk($sformatf("sweep%0d counters", c), {s_fwd_cnt, s_luse_cnt}, {m_fc, m_lc});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
